board_ctl: RTL and testbench

//  Playfield store and line-clear engine for the falling-block game. Answers the

---
 rtl/game_pkg.sv | 24 ++
 rtl/board_probe.sv | 25 ++
 rtl/board_ctl.sv | 155 +++++++++++++++
 tb/tb_board_ctl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared constants and encodings for the falling-block game: board size,
// block codes and the board controller's FSM states.
package game_pkg;
  localparam int COLS = 10;
  localparam int ROWS = 20;

  typedef enum logic [4:0] {
    BLK_I = 5'b10000,
    BLK_O = 5'b10001,
    BLK_T = 5'b10010,
    BLK_S = 5'b10011,
    BLK_Z = 5'b10100,
    BLK_J = 5'b10101,
    BLK_L = 5'b10110
  } block_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    SCAN  = 3'd2,
    SHIFT = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/board_probe.sv
// Combinational probe: does any of the four squares hit the floor or an
// occupied cell one row below? Squares off the right edge are ignored.
module board_probe #(
  parameter int COLS = game_pkg::COLS,
  parameter int ROWS = game_pkg::ROWS
) (
  input  logic [3:0][3:0]       sq_col,
  input  logic [3:0][4:0]       sq_row,
  input  logic [ROWS*COLS-1:0]  board,
  output logic                  hit
);
  import game_pkg::*;

  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (int'(sq_col[i]) < COLS) begin
        if (int'(sq_row[i]) + 1 >= ROWS)
          hit = 1'b1;
        else if (board[(int'(sq_row[i]) + 1) * COLS + int'(sq_col[i])])
          hit = 1'b1;
      end
    end
  end
endmodule

// File: rtl/board_ctl.sv
// Playfield store and line-clear engine: locks the active piece into the board,
// removes full rows by shifting the rows above down, and serves a row read port.
module board_ctl #(
  parameter int COLS    = game_pkg::COLS,
  parameter int ROWS    = game_pkg::ROWS,
  parameter int TOTAL_W = 16
) (
  input  logic               pclk,
  input  logic               rst,
  input  logic               lock_en,
  input  logic [3:0]         sq_1_col,
  input  logic [3:0]         sq_2_col,
  input  logic [3:0]         sq_3_col,
  input  logic [3:0]         sq_4_col,
  input  logic [4:0]         sq_1_row,
  input  logic [4:0]         sq_2_row,
  input  logic [4:0]         sq_3_row,
  input  logic [4:0]         sq_4_row,
  input  logic               board_clr,
  input  logic [4:0]         rd_row,
  output logic [COLS-1:0]    rd_data,
  output logic               collision,
  output logic               busy,
  output logic               clr_done,
  output logic [2:0]         clr_cnt,
  output logic [TOTAL_W-1:0] lines_total,
  output logic               game_over
);
  import game_pkg::*;

  localparam int N = ROWS * COLS;
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  state_t          state;
  logic [N-1:0]    board, board_nxt;
  logic [3:0][3:0] lat_col;
  logic [3:0][4:0] lat_row;
  logic [4:0]      ptr, k;
  logic [2:0]      n;
  logic            probe_hit, row_full, write_go;
  logic [TOTAL_W:0] total_sum;

  board_probe #(.COLS(COLS), .ROWS(ROWS)) u_probe (
    .sq_col ({sq_4_col, sq_3_col, sq_2_col, sq_1_col}),
    .sq_row ({sq_4_row, sq_3_row, sq_2_row, sq_1_row}),
    .board  (board),
    .hit    (probe_hit)
  );

  // The board is stale while a lock is being processed, so report a hit.
  assign collision = probe_hit | busy;
  assign row_full  = &board[int'(ptr) * COLS +: COLS];
  assign total_sum = {1'b0, lines_total} + (TOTAL_W + 1)'(n);

  function automatic logic sq_ok(input logic [3:0] c, input logic [4:0] r);
    return (int'(c) < COLS) && (int'(r) < ROWS);
  endfunction

  always_comb begin
    write_go = 1'b0;
    for (int i = 0; i < 4; i++)
      if (sq_ok(lat_col[i], lat_row[i]))
        if (lat_row[i] == 5'd0 || board[int'(lat_row[i]) * COLS + int'(lat_col[i])])
          write_go = 1'b1;
  end

  // Next-board datapath; rd_data is taken from this so reads see the current edge's update.
  always_comb begin
    board_nxt = board;
    case (state)
      IDLE:
        if (board_clr) board_nxt = '0;
      WRITE:
        for (int i = 0; i < 4; i++)
          if (sq_ok(lat_col[i], lat_row[i]))
            board_nxt[int'(lat_row[i]) * COLS + int'(lat_col[i])] = 1'b1;
      SHIFT: begin
        if (k != 5'd0)
          board_nxt[int'(k) * COLS +: COLS] = board[(int'(k) - 1) * COLS +: COLS];
        if (k <= 5'd1)
          board_nxt[0 +: COLS] = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      board       <= '0;
      rd_data     <= '0;
      busy        <= 1'b0;
      clr_done    <= 1'b0;
      clr_cnt     <= '0;
      lines_total <= '0;
      game_over   <= 1'b0;
      lat_col     <= '0;
      lat_row     <= '0;
      ptr         <= '0;
      k           <= '0;
      n           <= '0;
    end else begin
      board    <= board_nxt;
      rd_data  <= (int'(rd_row) < ROWS) ? board_nxt[int'(rd_row) * COLS +: COLS] : '0;
      clr_done <= 1'b0;
      case (state)
        IDLE: begin
          if (board_clr) begin
            lines_total <= '0;
            clr_cnt     <= '0;
            game_over   <= 1'b0;
          end else if (lock_en) begin
            lat_col <= {sq_4_col, sq_3_col, sq_2_col, sq_1_col};
            lat_row <= {sq_4_row, sq_3_row, sq_2_row, sq_1_row};
            busy    <= 1'b1;
            state   <= WRITE;
          end
        end
        WRITE: begin
          if (write_go) game_over <= 1'b1;
          ptr   <= LAST_ROW;
          n     <= '0;
          state <= SCAN;
        end
        SCAN: begin
          if (row_full) begin
            n     <= n + 3'd1;
            k     <= ptr;
            state <= SHIFT;
          end else if (ptr == 5'd0) begin
            state <= DONE;
          end else begin
            ptr <= ptr - 5'd1;
          end
        end
        // Returning to SCAN with ptr unchanged rechecks the row that just moved down.
        SHIFT: begin
          if (k != 5'd0) k <= k - 5'd1;
          if (k <= 5'd1) state <= SCAN;
        end
        DONE: begin
          clr_done    <= 1'b1;
          clr_cnt     <= n;
          lines_total <= total_sum[TOTAL_W] ? '1 : total_sum[TOTAL_W-1:0];
          busy        <= 1'b0;
          state       <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_board_ctl.sv
// Directed self-checking bench for board_ctl: locking, line clears, collision,
// game-over handling and asynchronous reset in the middle of a shift.
module tb_board_ctl;
  localparam logic [3:0] UC = 4'd15;
  localparam logic [4:0] UR = 5'd31;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        lock_en = 1'b0;
  logic [3:0]  sq_1_col = UC, sq_2_col = UC, sq_3_col = UC, sq_4_col = UC;
  logic [4:0]  sq_1_row = UR, sq_2_row = UR, sq_3_row = UR, sq_4_row = UR;
  logic        board_clr = 1'b0;
  logic [4:0]  rd_row = 5'd19;
  logic [9:0]  rd_data;
  logic        collision, busy, clr_done, game_over;
  logic [2:0]  clr_cnt;
  logic [15:0] lines_total;

  int checks = 0;
  int errors = 0;
  int latency, busyCycles;
  logic collMid;
  logic [9:0] rowData, rowAcc;

  board_ctl dut (
    .pclk(pclk), .rst(rst), .lock_en(lock_en),
    .sq_1_col(sq_1_col), .sq_2_col(sq_2_col), .sq_3_col(sq_3_col), .sq_4_col(sq_4_col),
    .sq_1_row(sq_1_row), .sq_2_row(sq_2_row), .sq_3_row(sq_3_row), .sq_4_row(sq_4_row),
    .board_clr(board_clr), .rd_row(rd_row), .rd_data(rd_data),
    .collision(collision), .busy(busy), .clr_done(clr_done), .clr_cnt(clr_cnt),
    .lines_total(lines_total), .game_over(game_over)
  );

  always #5 pclk = ~pclk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive the four squares; optionally pulse lock_en and wait (bounded) for clr_done.
  task automatic applyStimulus(input logic [15:0] cols, input logic [19:0] rows,
                               input bit doLock, input bit waitDone);
    @(negedge pclk);
    {sq_4_col, sq_3_col, sq_2_col, sq_1_col} = cols;
    {sq_4_row, sq_3_row, sq_2_row, sq_1_row} = rows;
    if (doLock) begin
      lock_en = 1'b1;
      @(posedge pclk);
      #1;
      lock_en    = 1'b0;
      latency    = 0;
      busyCycles = busy ? 1 : 0;
      collMid    = 1'b0;
      if (waitDone) begin
        while (latency < 400 && !clr_done) begin
          @(posedge pclk);
          #1;
          latency++;
          if (busy) busyCycles++;
          if (latency == 3) collMid = collision;
        end
        checkOutput("clr_done_seen", 32'(clr_done), 32'd1);
      end
    end
  endtask

  task automatic readRow(input logic [4:0] r, output logic [9:0] d);
    @(negedge pclk);
    rd_row = r;
    @(posedge pclk);
    #1;
    d = rd_data;
  endtask

  task automatic clearBoard();
    @(negedge pclk);
    board_clr = 1'b1;
    @(posedge pclk);
    #1;
    board_clr = 1'b0;
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(posedge pclk);
    @(negedge pclk);
    rst = 1'b0;

    // Reset state
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_clr_done", 32'(clr_done), 32'd0);
    checkOutput("rst_clr_cnt", 32'(clr_cnt), 32'd0);
    checkOutput("rst_lines", 32'(lines_total), 32'd0);
    checkOutput("rst_game_over", 32'(game_over), 32'd0);
    readRow(5'd19, rowData);
    checkOutput("rst_row19", 32'(rowData), 32'd0);
    applyStimulus({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd5}}, 1'b0, 1'b0);
    #1;
    checkOutput("coll_row5_free", 32'(collision), 32'd0);

    // Simple lock, no clears
    applyStimulus({4'd6, 4'd5, 4'd4, 4'd3}, {4{5'd19}}, 1'b1, 1'b1);
    checkOutput("lock_latency", 32'(latency), 32'd22);
    checkOutput("lock_busy_cycles", 32'(busyCycles), 32'd22);
    checkOutput("lock_clr_cnt", 32'(clr_cnt), 32'd0);
    checkOutput("lock_lines", 32'(lines_total), 32'd0);
    readRow(5'd19, rowData);
    checkOutput("lock_row19", 32'(rowData), 32'(10'b0001111000));
    readRow(5'd25, rowData);
    checkOutput("rd_out_of_range", 32'(rowData), 32'd0);

    // Single-row clear
    clearBoard();
    applyStimulus({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd19}}, 1'b1, 1'b1);
    applyStimulus({UC, 4'd0, 4'd5, 4'd4}, {UR, 5'd18, 5'd19, 5'd19}, 1'b1, 1'b1);
    applyStimulus({4'd9, 4'd8, 4'd7, 4'd6}, {4{5'd19}}, 1'b1, 1'b1);
    checkOutput("clr1_latency", 32'(latency), 32'd42);
    checkOutput("clr1_cnt", 32'(clr_cnt), 32'd1);
    checkOutput("clr1_lines", 32'(lines_total), 32'd1);
    readRow(5'd19, rowData);
    checkOutput("clr1_row19", 32'(rowData), 32'(10'b0000000001));
    readRow(5'd18, rowData);
    checkOutput("clr1_row18", 32'(rowData), 32'd0);

    // Four-row clear with a vertical I
    clearBoard();
    checkOutput("clr_lines_zero", 32'(lines_total), 32'd0);
    for (int r = 16; r <= 19; r++) begin
      applyStimulus({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'(r)}}, 1'b1, 1'b1);
      applyStimulus({4'd7, 4'd6, 4'd5, 4'd4}, {4{5'(r)}}, 1'b1, 1'b1);
    end
    applyStimulus({4{4'd8}}, {5'd19, 5'd18, 5'd17, 5'd16}, 1'b1, 1'b1);
    applyStimulus({4{4'd9}}, {5'd19, 5'd18, 5'd17, 5'd16}, 1'b1, 1'b1);
    checkOutput("clr4_latency", 32'(latency), 32'd102);
    checkOutput("clr4_busy_cycles", 32'(busyCycles), 32'd102);
    checkOutput("clr4_cnt", 32'(clr_cnt), 32'd4);
    checkOutput("clr4_lines", 32'(lines_total), 32'd4);
    checkOutput("clr4_game_over", 32'(game_over), 32'd0);
    rowAcc = '0;
    for (int r = 0; r < 20; r++) begin
      readRow(5'(r), rowData);
      rowAcc |= rowData;
    end
    checkOutput("clr4_board_empty", 32'(rowAcc), 32'd0);

    // Collision probes
    clearBoard();
    applyStimulus({UC, UC, UC, 4'd4}, {UR, UR, UR, 5'd11}, 1'b1, 1'b1);
    applyStimulus({UC, UC, UC, 4'd4}, {UR, UR, UR, 5'd10}, 1'b0, 1'b0);
    #1;
    checkOutput("coll_cell_below", 32'(collision), 32'd1);
    applyStimulus({UC, UC, UC, 4'd4}, {UR, UR, UR, 5'd9}, 1'b0, 1'b0);
    #1;
    checkOutput("coll_two_above", 32'(collision), 32'd0);
    applyStimulus({UC, UC, UC, 4'd2}, {UR, UR, UR, 5'd19}, 1'b0, 1'b0);
    #1;
    checkOutput("coll_floor", 32'(collision), 32'd1);
    applyStimulus({UC, UC, UC, UC}, {5'd19, 5'd19, 5'd19, 5'd19}, 1'b0, 1'b0);
    #1;
    checkOutput("coll_col_ignored", 32'(collision), 32'd0);

    // Game over from a row-0 lock, then new game
    applyStimulus({UC, UC, UC, 4'd5}, {UR, UR, UR, 5'd0}, 1'b1, 1'b1);
    checkOutput("go_latency", 32'(latency), 32'd22);
    checkOutput("coll_forced_busy", 32'(collMid), 32'd1);
    checkOutput("go_set", 32'(game_over), 32'd1);
    checkOutput("coll_after_done", 32'(collision), 32'd0);
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("go_held", 32'(game_over), 32'd1);
    clearBoard();
    checkOutput("go_cleared", 32'(game_over), 32'd0);
    readRow(5'd0, rowData);
    checkOutput("newgame_row0", 32'(rowData), 32'd0);

    // Asynchronous reset while shifting
    applyStimulus({4'd3, 4'd2, 4'd1, 4'd0}, {4{5'd19}}, 1'b1, 1'b1);
    applyStimulus({4'd7, 4'd6, 4'd5, 4'd4}, {4{5'd19}}, 1'b1, 1'b1);
    applyStimulus({UC, UC, 4'd9, 4'd8}, {UR, UR, 5'd19, 5'd19}, 1'b1, 1'b0);
    repeat (3) @(posedge pclk);
    #1;
    checkOutput("mid_shift_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    checkOutput("rst_mid_busy", 32'(busy), 32'd0);
    checkOutput("rst_mid_clr_done", 32'(clr_done), 32'd0);
    checkOutput("rst_mid_rd_data", 32'(rd_data), 32'd0);
    @(negedge pclk);
    rst = 1'b0;
    readRow(5'd19, rowData);
    checkOutput("rst_mid_row19", 32'(rowData), 32'd0);
    checkOutput("rst_mid_lines", 32'(lines_total), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
